test_ctrl: RTL and testbench
============================

Name: test_ctrl

Overview:
- Synthesizable simulation-control block that sits between the top-level bench and the core, replacing a fixed, hand-timed reset pulse.
- Generates a parametrised core reset and counts run cycles.
- Snoops data-memory stores for a tohost completion write (riscv-tests convention), with a watchdog timeout.
- On completion, freezes the core and streams the compliance signature region word by word over a valid/ready port.

Parameters:
- XLEN, 32, data/address width.
- RESET_CYCLES, 4, clocks core_reset stays high after reset deasserts; must be >= 1.
- TIMEOUT_CYCLES, 100000, RUN-cycle budget before timeout; must be >= 1.
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word.
- SIG_BEGIN, 32'h0000_2000, first signature byte address (inclusive).
- SIG_END, 32'h0000_2010, end signature byte address (exclusive).
- CNT_W, 32, cycle counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- core_reset  out  1  reset to core
- mem_we  in  1  data-memory write strobe
- mem_addr  in  XLEN  data-memory write address
- mem_wdata  in  XLEN  data-memory write data
- sig_valid  out  1  signature word available
- sig_ready  in  1  bench accepts word
- sig_addr  out  XLEN  signature word address, also drives the memory read port
- sig_rdata  in  XLEN  combinational memory read data at sig_addr
- sig_data  out  XLEN  equals sig_rdata
- cycle_count  out  CNT_W  RUN cycles elapsed
- done  out  1  test finished
- pass  out  1  tohost value == 1
- timeout  out  1  watchdog expired
- exit_code  out  XLEN-1  tohost wdata[XLEN-1:1]

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset values: core_reset=1, sig_addr=SIG_BEGIN. done, pass, timeout, exit_code, cycle_count, sig_valid all 0. State HOLD, hold counter 0.
- Reset asserted mid-operation, any state: immediate return to reset values. All registered outputs and state are registered.
- HOLD:
  - Hold counter increments each clk.
  - When counter == RESET_CYCLES-1, go to RUN.
  - core_reset falls on that same edge, so it is high for exactly RESET_CYCLES rising edges after reset deasserts.
- RUN:
  - core_reset=0.
  - cycle_count increments every RUN cycle, saturating at all-ones.
  - A valid tohost write is mem_we=1, mem_addr==TOHOST_ADDR and mem_wdata[0]=1. On one:
    - latch exit_code=mem_wdata[XLEN-1:1];
    - pass=(mem_wdata==1);
    - go to DUMP.
  - Ignored: writes with wdata[0]=0 (syscall convention) and writes to any other address.
  - Timeout: cycle_count==TIMEOUT_CYCLES-1 (pre-increment) with no valid tohost write that cycle sets timeout=1 and pass=0, then go to DUMP. The final cycle_count is then TIMEOUT_CYCLES.
  - Simultaneous tohost write and timeout: tohost wins, timeout stays 0.
  - A tohost write in the same cycle as cycle_count==N leaves a final count of N+1.
- DUMP:
  - core_reset=1 (freezes the core); cycle_count frozen.
  - sig_valid=1 and sig_addr begins at SIG_BEGIN; sig_data tracks sig_rdata combinationally.
  - On sig_valid && sig_ready, sig_addr += 4.
  - The transfer at SIG_END-4 goes to FINISH with sig_valid=0.
  - If SIG_BEGIN==SIG_END, pass straight from RUN to FINISH (no transfers).
  - When sig_ready is low, sig_addr holds and no word is skipped or duplicated.
- FINISH:
  - done=1; core_reset=1; pass, timeout, exit_code and cycle_count are held.
  - Sticky until reset.
- Elaboration checks ($error):
  - TOHOST_ADDR, SIG_BEGIN and SIG_END are 4-byte aligned;
  - SIG_END >= SIG_BEGIN;
  - RESET_CYCLES >= 1 and TIMEOUT_CYCLES >= 1.

Decomposition:
- Shared package test_ctrl_pkg: state enum {HOLD, RUN, DUMP, FINISH}, WORD_BYTES=4, TOHOST_PASS_VALUE=1.
- One natural sub-module: sat_counter (parametrised width, enable, sync clear, async reset, saturate), used for both the hold counter and cycle_count.

Test Plan:
Bench parameters for all scenarios: RESET_CYCLES=3, TIMEOUT_CYCLES=50, TOHOST=0x1000, SIG 0x2000–0x2010.
- Reset release: reset high 2 clocks, then low -> core_reset high for exactly 3 rising edges after deassert and low from the 4th; cycle_count=0 until RUN.
- Pass: write 0x1000<=0x1 while cycle_count==10, sig_ready tied 1 -> pass=1, exit_code=0, sig_addr 0x2000, 0x2004, 0x2008, 0x200C on consecutive cycles; then done=1, cycle_count=11.
- Fail code: write 0x1000<=0x7 -> pass=0, exit_code=3, timeout=0, done after 4 signature transfers.
- Ignored writes: 0x1000<=0x2 and 0x1004<=0x1 -> stays in RUN, core_reset=0, done=0; timeout=1 with cycle_count=50, then 4 transfers; sig_ready alternating 1,0 -> each address held across ready-low cycles, 4 transfers total in 8 cycles.
- Tie-break: write 0x1000<=0x1 at cycle_count==49 -> pass=1, timeout=0.
- Mid-op reset: assert reset while sig_addr==0x2008 -> core_reset=1, sig_valid=0, done=0 immediately, before the next clk edge. After release, a full 3-cycle HOLD and counters restart from 0.

Source files
------------

// File: rtl/test_ctrl_pkg.sv
// test_ctrl_pkg: shared state encoding and constants for the simulation control block
package test_ctrl_pkg;
    typedef enum logic [1:0] {HOLD, RUN, DUMP, FINISH} state_t;
    localparam int WORD_BYTES = 4;
    localparam int TOHOST_PASS_VALUE = 1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter with enable, sync clear and async reset that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (clr) q <= '0;
        else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/test_ctrl.sv
// test_ctrl: core reset sequencing, tohost completion/watchdog detection and signature streaming
module test_ctrl
    import test_ctrl_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              RESET_CYCLES   = 4,
    parameter int              TIMEOUT_CYCLES = 100000,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [XLEN-1:0] SIG_BEGIN      = 32'h0000_2000,
    parameter logic [XLEN-1:0] SIG_END        = 32'h0000_2010,
    parameter int              CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             core_reset,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [XLEN-1:0]  sig_addr,
    input  logic [XLEN-1:0]  sig_rdata,
    output logic [XLEN-1:0]  sig_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-2:0]  exit_code
);
    localparam logic [XLEN-1:0]  SIG_LAST  = SIG_END - XLEN'(WORD_BYTES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam bit               NO_SIG    = SIG_BEGIN == SIG_END;

    if (TOHOST_ADDR[1:0] != 2'b00 || SIG_BEGIN[1:0] != 2'b00 || SIG_END[1:0] != 2'b00) begin : g_align
        $error("test_ctrl: TOHOST_ADDR, SIG_BEGIN and SIG_END must be word aligned");
    end
    if (SIG_END < SIG_BEGIN) begin : g_order
        $error("test_ctrl: SIG_END must not be below SIG_BEGIN");
    end
    if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cycles
        $error("test_ctrl: RESET_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state;
    logic [31:0] hold_cnt;
    logic        tohost_hit;
    logic        to_hit;

    sat_counter #(.W(32)) u_hold (
        .clk   (clk),
        .reset (reset),
        .en    (state == HOLD),
        .clr   (1'b0),
        .q     (hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .reset (reset),
        .en    (state == RUN),
        .clr   (1'b0),
        .q     (cycle_count)
    );

    assign tohost_hit = mem_we && mem_addr == TOHOST_ADDR && mem_wdata[0];
    assign to_hit     = cycle_count == TO_LAST;
    assign sig_data   = sig_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            core_reset <= 1'b1;
            sig_valid  <= 1'b0;
            sig_addr   <= SIG_BEGIN;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            exit_code  <= '0;
        end else begin
            case (state)
                HOLD: if (hold_cnt == HOLD_LAST) begin
                    state      <= RUN;
                    core_reset <= 1'b0;
                end
                RUN: if (tohost_hit || to_hit) begin
                    // a tohost write in the timeout cycle takes priority
                    if (tohost_hit) begin
                        exit_code <= mem_wdata[XLEN-1:1];
                        pass      <= mem_wdata == XLEN'(TOHOST_PASS_VALUE);
                    end else begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                    core_reset <= 1'b1;
                    sig_valid  <= !NO_SIG;
                    done       <= NO_SIG;
                    state      <= NO_SIG ? FINISH : DUMP;
                end
                DUMP: if (sig_ready) begin
                    sig_addr <= sig_addr + XLEN'(WORD_BYTES);
                    if (sig_addr == SIG_LAST) begin
                        sig_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_test_ctrl.sv
// tb_test_ctrl: table-driven completion scenarios with a signature scoreboard, plus reset corner cases
module tb_test_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_reset;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        sig_valid;
    logic        sig_ready = 1'b0;
    logic [31:0] sig_addr;
    logic [31:0] sig_rdata;
    logic [31:0] sig_data;
    logic [31:0] cycle_count;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] exit_code;

    always #5 clk = ~clk;

    test_ctrl #(
        .XLEN(32), .RESET_CYCLES(3), .TIMEOUT_CYCLES(50),
        .TOHOST_ADDR(32'h1000), .SIG_BEGIN(32'h2000), .SIG_END(32'h2010), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .core_reset(core_reset),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_addr(sig_addr),
        .sig_rdata(sig_rdata), .sig_data(sig_data), .cycle_count(cycle_count),
        .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code)
    );

    logic [31:0] sigmem [4] = '{32'hA500_0000, 32'hA501_0101, 32'hA502_0202, 32'hA503_0303};

    always_comb sig_rdata = (sig_addr >= 32'h2000 && sig_addr < 32'h2010) ? sigmem[sig_addr[3:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        int          wr_at;
        logic [31:0] waddr;
        logic [31:0] wdata;
        bit          alt;
        bit          exp_pass;
        logic [30:0] exp_exit;
        bit          exp_to;
        int          exp_cnt;
    } vec_t;

    xfer_t sb[$];
    vec_t  vecs[6];
    int    checks = 0;
    int    passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic sb_pop();
        xfer_t x;
        if (sb.size() == 0) begin
            chk("sb_extra_transfer", 64'(sig_addr), 64'hFFFF_FFFF);
        end else begin
            x = sb.pop_front();
            chk("sig_addr", 64'(sig_addr), 64'(x.addr));
            chk("sig_data", 64'(sig_data), 64'(x.data));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_we = 1'b0;
        sig_ready = 1'b0;
        #1;
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_sig_valid", 64'(sig_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sig_addr", 64'(sig_addr), 64'h2000);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("rst_pass_timeout", {62'd0, pass, timeout}, 64'd0);
        chk("rst_exit_code", 64'(exit_code), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk("hold_core_reset", 64'(core_reset), (e < 3) ? 64'd1 : 64'd0);
            chk("hold_cycle_count", 64'(cycle_count), (e < 4) ? 64'd0 : 64'd1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc;
        int  vcyc;
        bit  wrote;
        logic [31:0] cnt_end;
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back('{32'h2000 + 32'(4 * i), sigmem[i]});
        cyc = 0;
        vcyc = 0;
        wrote = 1'b0;
        while (!done && cyc < 300) begin
            if (mem_we) begin
                mem_we = 1'b0;
                chk("after_write_core_reset", 64'(core_reset), v.exp_to ? 64'd0 : 64'd1);
                chk("after_write_done", 64'(done), 64'd0);
            end
            if (!wrote && !core_reset && cycle_count == 32'(v.wr_at)) begin
                mem_we = 1'b1;
                mem_addr = v.waddr;
                mem_wdata = v.wdata;
                wrote = 1'b1;
            end
            if (sig_valid) begin
                vcyc++;
                sig_ready = v.alt ? (vcyc % 2 == 0) : 1'b1;
                if (sig_ready) sb_pop();
            end else begin
                sig_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done", 64'(done), 64'd1);
        chk("pass", 64'(pass), 64'(v.exp_pass));
        chk("exit_code", 64'(exit_code), 64'(v.exp_exit));
        chk("timeout", 64'(timeout), 64'(v.exp_to));
        chk("cycle_count", 64'(cycle_count), 64'(v.exp_cnt));
        chk("final_sig_valid", 64'(sig_valid), 64'd0);
        chk("final_core_reset", 64'(core_reset), 64'd1);
        chk("sb_left", 64'(sb.size()), 64'd0);
        chk("valid_cycles", 64'(vcyc), v.alt ? 64'd8 : 64'd4);
        sb.delete();
        cnt_end = cycle_count;
        sig_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_sticky", {62'd0, done, sig_valid}, 64'd2);
        chk("count_frozen", 64'(cycle_count), 64'(cnt_end));
    endtask

    initial begin
        int cyc;
        vecs[0] = '{10, 32'h1000, 32'h0000_0001, 1'b0, 1'b1, 31'd0, 1'b0, 11};
        vecs[1] = '{5,  32'h1000, 32'h0000_0007, 1'b0, 1'b0, 31'd3, 1'b0, 6};
        vecs[2] = '{5,  32'h1000, 32'h0000_0002, 1'b1, 1'b0, 31'd0, 1'b1, 50};
        vecs[3] = '{7,  32'h1004, 32'h0000_0001, 1'b0, 1'b0, 31'd0, 1'b1, 50};
        vecs[4] = '{49, 32'h1000, 32'h0000_0001, 1'b0, 1'b1, 31'd0, 1'b0, 50};
        vecs[5] = '{20, 32'h1000, 32'h8000_0001, 1'b1, 1'b0, 31'h4000_0000, 1'b0, 21};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        do_reset();
        cyc = 0;
        while (sig_addr != 32'h2008 && cyc < 100) begin
            mem_we = !core_reset && cycle_count == 32'd3;
            mem_addr = 32'h1000;
            mem_wdata = 32'h1;
            sig_ready = sig_valid;
            @(negedge clk);
            cyc++;
        end
        mem_we = 1'b0;
        sig_ready = 1'b0;
        chk("mid_reached_2008", 64'(sig_addr), 64'h2008);
        chk("mid_valid_before", 64'(sig_valid), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_core_reset", 64'(core_reset), 64'd1);
        chk("mid_sig_valid", 64'(sig_valid), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_sig_addr", 64'(sig_addr), 64'h2000);
        chk("mid_cycle_count", 64'(cycle_count), 64'd0);
        chk("mid_pass", 64'(pass), 64'd0);
        do_reset();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
